// File: rtl/dso_pkg.sv
// Shared types and encodings for the multi-channel DSO capture block.
//   state_t     : capture FSM states (also exported on the status port)
//   MODE_*      : acquisition mode encodings (3 behaves like normal)
//   EDGE_*      : trigger edge encodings (2 and 3 both mean either edge)
package dso_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE_FILL  = 3'd1,
    ARMED     = 3'd2,
    POST_FILL = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_BOTH = 2'd2;

endpackage

// File: rtl/dso_trig_detect.sv
// Trigger detector: selects one channel, derives saturating hysteresis
// thresholds and tracks the rising/falling arm flags.
//   clk, rst    : clock, async active-high reset
//   ad_data     : all channel samples, ch0 in LSBs
//   ad_valid    : sample strobe
//   clr         : hold both arm flags cleared (capture not running)
//   trig_src    : channel select, out-of-range selects ch0
//   trig_edge   : rising / falling / either
//   trig_level  : threshold; trig_hyst: hysteresis band
//   fire        : combinational, a trigger on the current valid sample
module dso_trig_detect import dso_pkg::*; #(
  parameter int NCH    = 2,
  parameter int DATA_W = 8,
  parameter int CW     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*DATA_W-1:0]   ad_data,
  input  logic                    ad_valid,
  input  logic                    clr,
  input  logic [CW-1:0]           trig_src,
  input  logic [1:0]              trig_edge,
  input  logic [DATA_W-1:0]       trig_level,
  input  logic [DATA_W-1:0]       trig_hyst,
  output logic                    fire
);

  logic [DATA_W-1:0] s, lo, hi;
  logic [DATA_W:0]   sum;
  logic              arm_r, arm_f;
  logic              rise_hit, fall_hit, rise_en, fall_en;

  // Unmatched select values fall through to ch0.
  always_comb begin
    s = ad_data[DATA_W-1:0];
    for (int i = 1; i < NCH; i++)
      if (int'(trig_src) == i) s = ad_data[i*DATA_W +: DATA_W];
  end

  // Thresholds clamp at the code range instead of wrapping.
  assign sum = {1'b0, trig_level} + {1'b0, trig_hyst};
  assign hi  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  assign lo  = (trig_level > trig_hyst) ? trig_level - trig_hyst : '0;

  assign rise_hit = arm_r && (s >= trig_level);
  assign fall_hit = arm_f && (s <= trig_level);
  assign rise_en  = (trig_edge == EDGE_RISE) || (trig_edge >= EDGE_BOTH);
  assign fall_en  = (trig_edge == EDGE_FALL) || (trig_edge >= EDGE_BOTH);
  assign fire     = ad_valid && ((rise_en && rise_hit) || (fall_en && fall_hit));

  // A hit consumes the arm flag; the signal must leave the band again
  // before the next trigger, which is what suppresses noise re-triggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_r <= 1'b0;
      arm_f <= 1'b0;
    end else if (clr) begin
      arm_r <= 1'b0;
      arm_f <= 1'b0;
    end else if (ad_valid) begin
      arm_r <= !rise_hit && (arm_r || (s < lo));
      arm_f <= !fall_hit && (arm_f || (s > hi));
    end
  end

endmodule

// File: rtl/dso_multi_capture.sv
// Multi-channel capture controller: circular record buffer with runtime
// pre-trigger length, selectable trigger and auto/normal/single modes.
//   ad_clk, rst   : sole clock, async active-high reset
//   ad_data/valid : decimated samples (ch0 in LSBs) and strobe
//   run, mode     : acquisition enable and mode
//   trig_*        : trigger channel, edge, level, hysteresis
//   pre_len       : pre-trigger samples, latched at capture start
//   rearm         : readout finished (auto/normal restart)
//   rd_en/rd_addr : record-relative read, 0 = oldest sample
//   rd_data/valid : registered read data, one cycle latency
//   capture_done, triggered, state : status
module dso_multi_capture import dso_pkg::*; #(
  parameter  int NCH          = 2,
  parameter  int DATA_W       = 8,
  parameter  int DEPTH        = 1024,
  parameter  int AUTO_TIMEOUT = 4096,
  localparam int AW           = $clog2(DEPTH),
  localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  ad_clk,
  input  logic                  rst,
  input  logic [NCH*DATA_W-1:0] ad_data,
  input  logic                  ad_valid,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic [CW-1:0]         trig_src,
  input  logic [1:0]            trig_edge,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic [DATA_W-1:0]     trig_hyst,
  input  logic [AW-1:0]         pre_len,
  input  logic                  rearm,
  input  logic                  rd_en,
  input  logic [AW:0]           rd_addr,
  output logic [NCH*DATA_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  capture_done,
  output logic                  triggered,
  output logic [2:0]            state
);

  localparam int          DW      = NCH * DATA_W;
  localparam int          TW      = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(AUTO_TIMEOUT - 1);

  state_t        st;
  logic [AW-1:0] wr_ptr, trig_ptr, pre_q, rd_phys;
  logic [AW:0]   cnt, post_q;
  logic [TW-1:0] to_cnt;
  logic          run_q;
  logic          active, we, fire, force_trig, start;
  logic [DW-1:0] mem [DEPTH];

  assign state      = st;
  assign active     = (st == PRE_FILL) || (st == ARMED) || (st == POST_FILL);
  assign we         = ad_valid && active;
  // Post length includes the trigger sample, so pre + post = DEPTH.
  assign post_q     = DEPTH_V - {1'b0, pre_q};
  assign force_trig = (mode == MODE_AUTO) && (to_cnt == TO_LAST);

  // Single mode restarts only on a fresh run edge; otherwise rearm restarts.
  assign start = (st == IDLE && run) ||
                 (st == DONE && ((mode == MODE_SINGLE) ? (run && !run_q)
                                                        : (rearm && run)));

  dso_trig_detect #(.NCH(NCH), .DATA_W(DATA_W), .CW(CW)) u_trig (
    .clk        (ad_clk),
    .rst        (rst),
    .ad_data    (ad_data),
    .ad_valid   (ad_valid),
    .clr        (!active),
    .trig_src   (trig_src),
    .trig_edge  (trig_edge),
    .trig_level (trig_level),
    .trig_hyst  (trig_hyst),
    .fire       (fire)
  );

  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      wr_ptr       <= '0;
      trig_ptr     <= '0;
      pre_q        <= '0;
      cnt          <= '0;
      to_cnt       <= '0;
      run_q        <= 1'b0;
      capture_done <= 1'b0;
      triggered    <= 1'b0;
    end else begin
      run_q <= run;
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (start) begin
        pre_q        <= pre_len;
        cnt          <= '0;
        to_cnt       <= '0;
        capture_done <= 1'b0;
        st           <= (pre_len == '0) ? ARMED : PRE_FILL;
      end else begin
        case (st)
          IDLE: begin
            capture_done <= 1'b0;
            cnt          <= '0;
            to_cnt       <= '0;
          end
          PRE_FILL: begin
            if (!run) st <= IDLE;
            else if (ad_valid) begin
              if (cnt + 1'b1 == {1'b0, pre_q}) begin
                cnt <= '0;
                st  <= ARMED;
              end else cnt <= cnt + 1'b1;
            end
          end
          ARMED: begin
            if (!run) st <= IDLE;
            else if (ad_valid) begin
              if (fire || force_trig) begin
                // A real fire on the timeout sample still reports triggered.
                trig_ptr  <= wr_ptr;
                triggered <= fire;
                cnt       <= (AW+1)'(1);
                if (post_q == (AW+1)'(1)) begin
                  st           <= DONE;
                  capture_done <= 1'b1;
                end else st <= POST_FILL;
              end else if (mode == MODE_AUTO) to_cnt <= to_cnt + 1'b1;
            end
          end
          POST_FILL: begin
            if (!run) st <= IDLE;
            else if (ad_valid) begin
              cnt <= cnt + 1'b1;
              if (cnt + 1'b1 == post_q) begin
                st           <= DONE;
                capture_done <= 1'b1;
              end
            end
          end
          DONE:    st <= DONE;
          default: st <= IDLE;
        endcase
      end
    end
  end

  // Record buffer: one write port, one registered read port.
  always_ff @(posedge ad_clk) begin
    if (we) mem[wr_ptr] <= ad_data;
  end

  // Oldest sample sits pre_q entries before the trigger; AW-bit math wraps.
  assign rd_phys = trig_ptr - pre_q + rd_addr[AW-1:0];

  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_addr[AW] ? '1 : mem[rd_phys];
    end
  end

endmodule

// File: doc/dso_multi_capture.md
Name: dso_multi_capture

Overview:
Multi-channel, single-clock capture controller for the DSO front end, successor to the single-channel trigger/store block. It records NCH decimated AD channels into an internal circular buffer, with:
- runtime pre-trigger length;
- selectable trigger channel and edge;
- trigger hysteresis;
- auto/normal/single acquisition modes.
Sits between the decimator (ad_valid) and the display readout; any clock crossing to the display domain is external.

Parameters:
NCH, 2, number of channels (>=1)
DATA_W, 8, bits per channel sample
DEPTH, 1024, samples per channel per record; power of two, >=4
AUTO_TIMEOUT, 4096, ARMED-state valid samples before a forced trigger in auto mode
(localparams) AW = clog2(DEPTH); CW = max(1, clog2(NCH))

Ports:
ad_clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
ad_data  in  NCH*DATA_W  channel samples, ch0 in LSBs
ad_valid  in  1  sample strobe (decimation valid)
run  in  1  acquisition enable
mode  in  2  0 auto, 1 normal, 2 single, 3 treated as normal
trig_src  in  CW  trigger channel; values >=NCH select ch0
trig_edge  in  2  0 rising, 1 falling, 2/3 either
trig_level  in  DATA_W  trigger threshold
trig_hyst  in  DATA_W  hysteresis band
pre_len  in  AW  pre-trigger samples
rearm  in  1  pulse: readout finished
rd_en  in  1  read request
rd_addr  in  AW+1  record-relative index; 0 = oldest sample
rd_data  out  NCH*DATA_W  registered read data
rd_valid  out  1  rd_en delayed one cycle
capture_done  out  1  record complete and frozen
triggered  out  1  last record had a real trigger (0 = auto-forced)
state  out  3  FSM state, for debug and status

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer 0; hysteresis arm flags 0; timeout counter 0.
- FSM states: IDLE, PRE_FILL, ARMED, POST_FILL, DONE.
- Entering a capture:
  - pre_len is latched into pre_q as the capture starts; mid-capture changes are ignored.
  - post_q = DEPTH - pre_q, counted including the trigger sample.
- IDLE:
  - run=1 -> PRE_FILL, or ARMED if pre_len==0.
  - Clears capture_done and the counters.
- PRE_FILL:
  - Writes every ad_valid sample.
  - After pre_q writes -> ARMED.
- ARMED:
  - Writes circularly, overwriting the oldest pre-trigger data.
  - On a fire decision with ad_valid high, that sample is the trigger sample: trig_ptr = its write address, triggered<=1, go to POST_FILL.
  - Auto mode: a counter counts valid samples while in ARMED. If it reaches AUTO_TIMEOUT, the current sample is force-triggered with triggered<=0.
  - A real fire on the same sample as the timeout wins (triggered=1).
- POST_FILL:
  - Writes until post_q samples have been written since the trigger, then DONE with capture_done=1.
- DONE:
  - Writes blocked; buffer frozen.
  - Auto/normal: rearm && run -> re-enter as from IDLE (pre_len re-latched).
  - Single: rearm is ignored; leaves DONE only on a 0->1 transition of run (run sampled every cycle).
  - run=0 in DONE holds DONE.
- run=0 in PRE_FILL/ARMED/POST_FILL aborts to IDLE on the next edge.
- Trigger detection on the selected channel s; thresholds saturate at 0 / 2^DATA_W-1:
  - Rising: arm_r<=1 when s < level-hyst. Fires when arm_r && s>=level; arm_r clears on fire.
  - Falling: arm_f<=1 when s > level+hyst. Fires when arm_f && s<=level; arm_f clears on fire.
  - Either edge: the OR of both.
  - Flags update on ad_valid from PRE_FILL onward, so a record can trigger immediately on ARMED entry.
  - hyst=0 gives a plain crossing detector.
- Read path:
  - Physical address = (trig_ptr - pre_q + rd_addr) mod DEPTH.
  - rd_data is registered with latency 1.
  - rd_addr >= DEPTH returns all-ones on every channel (display out-of-range convention); rd_valid is still asserted.
  - A read and write to the same address in the same cycle returns the old data.
  - Reads outside DONE return memory contents with no guarantee of coherence.
- Memory: one DEPTH x (NCH*DATA_W) simple dual-port array, synchronous read.

Decomposition:
- Package dso_pkg:
  - state enum (IDLE..DONE);
  - mode encodings MODE_AUTO/NORMAL/SINGLE;
  - edge encodings EDGE_RISE/FALL/BOTH.
- Sub-module dso_trig_detect: channel mux plus saturating thresholds and hysteresis arm flags; outputs a combinational fire.
- The FSM, pointers and RAM stay in the top.

Test Plan:
Common setup unless stated: DEPTH=16, NCH=2, pre_len=4, ad_valid every cycle.
1. Normal mode, rising edge, level=100, hyst=10; ch0 ramps 0,1,2,... -> DONE after 12 post samples; rd_addr 0..15 returns ch0 = 96..111; rd_addr 4 = 100; triggered=1.
2. Falling edge, level=50, hyst=5, trig_src=1; ch1 is a square wave 60/40 held for 8 samples each -> trigger on the first 40 after the 60s; ch0 data captured alongside ch1.
3. Auto mode, AUTO_TIMEOUT=20, constant input 30, level=100 -> forced trigger after 20 armed samples; capture_done=1; triggered=0.
4. Hysteresis: level=100, hyst=10; input 95,101,95,101 then 80,101 -> no fire before 80; fires on the 101 after 80.
5. Single mode: after DONE, pulse rearm -> stays DONE. Drop run for one cycle and raise it -> new capture starts.
6. Abort and reset: drop run mid POST_FILL -> IDLE, capture_done=0. Assert rst mid ARMED -> all outputs 0 immediately. rd_addr=16 -> rd_data=0xFFFF, rd_valid=1.
